muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file, taking rs1/rs2 read data, and returns a 32-bit result plus a write-back address/enable to the register-file write port. The unit is multi-cycle: it asserts busy so the control path stalls PC/fetch until the result is written back.

---
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero / signed-overflow skip straight to DONE.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wb_addr,
    output logic            wb_en
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic              neg_q, neg_d;
    logic              special_q, special_d;
    logic [XLEN-1:0]   fin_q, fin_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wb_en_q, wb_en_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        wb_addr_q, wb_addr_d;

    // Operand decode at issue time
    logic            is_div, signed_a, signed_b, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b, spec_val;
    logic            div_zero, div_ovf;

    assign is_div   = funct3[2];
    assign signed_a = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign signed_b = is_div ? ~funct3[0] : ~funct3[1];
    assign a_neg    = signed_a & rs1_data[XLEN-1];
    assign b_neg    = signed_b & rs2_data[XLEN-1];
    assign mag_a    = a_neg ? -rs1_data : rs1_data;
    assign mag_b    = b_neg ? -rs2_data : rs2_data;
    assign div_zero = is_div && (rs2_data == '0);
    assign div_ovf  = is_div && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == ALL_ONE);
    assign spec_val = div_zero ? (funct3[1] ? rs1_data : ALL_ONE)
                               : (funct3[1] ? '0 : MIN_NEG);

    // Iteration datapath: multiply keeps {acc, multiplier}, divide keeps {remainder, quotient}
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_step, div_step, mul_signed;
    logic [XLEN-1:0]   div_val, fix_val;

    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step  = {mul_sum, prod_q[XLEN-1:1]};
    assign div_trial = prod_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    assign div_step  = div_trial[XLEN] ? {prod_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};

    assign mul_signed = neg_q ? -prod_q : prod_q;
    assign div_val    = op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
    assign fix_val    = op_q[2] ? (neg_q ? -div_val : div_val)
                                : ((op_q[1:0] == 2'b00) ? mul_signed[XLEN-1:0]
                                                        : mul_signed[2*XLEN-1:XLEN]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        opnd_d    = opnd_q;
        prod_d    = prod_q;
        neg_d     = neg_q;
        special_d = special_q;
        fin_d     = fin_q;
        // Outputs trail the state by one edge so every port comes straight from a flop
        busy_d    = (state_q != IDLE);
        done_d    = (state_q == DONE);
        wb_en_d   = (state_q == DONE) && (rd_q != 5'd0);
        result_d  = result_q;
        wb_addr_d = wb_addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = funct3;
                    rd_d      = rd_addr;
                    cnt_d     = '0;
                    opnd_d    = is_div ? mag_b : mag_a;
                    prod_d    = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                    neg_d     = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                    special_d = div_zero || div_ovf;
                    fin_d     = spec_val;
`ifdef MULDIV_EARLY_OUT_EN
                    state_d   = (div_zero || div_ovf) ? DONE : CALC;
`else
                    state_d   = CALC;
`endif
                end
            end
            CALC: begin
                prod_d = op_q[2] ? div_step : mul_step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (!special_q) begin
                    fin_d = fix_val;
                end
                state_d = DONE;
            end
            DONE: begin
                result_d  = fin_q;
                wb_addr_d = rd_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            opnd_q    <= '0;
            prod_q    <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            fin_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            result_q  <= '0;
            wb_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            opnd_q    <= opnd_d;
            prod_q    <= prod_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            fin_q     <= fin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wb_en_q   <= wb_en_d;
            result_q  <= result_d;
            wb_addr_q <= wb_addr_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wb_en   = wb_en_q;
    assign result  = result_q;
    assign wb_addr = wb_addr_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic, special cases, latency, reset abort, busy handling.
module tb_muldiv_unit;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 34;
`endif
    localparam int OP_LAT = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  rd_addr;
    logic        busy, done, wb_en;
    logic [31:0] result;
    logic [4:0]  wb_addr;

    int tests_run = 0;
    int fails     = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .wb_addr  (wb_addr),
        .wb_en    (wb_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait for done (bounded), check latency/busy/result/write-back.
    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy_bad;
        @(negedge clk);
        start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_addr = rd;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        busy_bad = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (!busy) busy_bad++;
        end
        check({name, "_done"},    32'(done), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy"},    32'(busy_bad), 32'd0);
        check({name, "_result"},  result, exp);
        check({name, "_wb_addr"}, 32'(wb_addr), 32'(rd));
        check({name, "_wb_en"},   32'(wb_en), 32'(rd != 5'd0));
        $display("[TB] %s f3=%0d a=%h b=%h rd=%0d -> result=%h lat=%0d", name, f3, a, b, rd, result, lat);
        @(posedge clk);
        #1;
        check({name, "_done_drop"}, 32'({done, wb_en, busy}), 32'd0);
        check({name, "_hold"},      result, exp);
    endtask

    initial begin
        int cnt;
        int lat;
        logic [31:0] got;

        reset = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",    32'(busy), 32'd0);
        check("reset_done",    32'(done), 32'd0);
        check("reset_wb_en",   32'(wb_en), 32'd0);
        check("reset_result",  result, 32'd0);
        check("reset_wb_addr", 32'(wb_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op("mul_neg",    3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, OP_LAT);
        do_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, OP_LAT);
        do_op("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, OP_LAT);
        do_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, OP_LAT);
        do_op("mul_low",    3'd0, 32'h1234_5678, 32'h0000_0010, 5'd9,  32'h2345_6780, OP_LAT);
        do_op("mulhu_hi",   3'd3, 32'h1234_5678, 32'h0000_0010, 5'd10, 32'h0000_0001, OP_LAT);
        do_op("div_neg",    3'd4, 32'hFFFF_FFF9, 32'd2,        5'd11, 32'hFFFF_FFFD, OP_LAT);
        do_op("rem_neg",    3'd6, 32'hFFFF_FFF9, 32'd2,        5'd12, 32'hFFFF_FFFF, OP_LAT);
        do_op("divu_big",   3'd5, 32'hFFFF_FFF9, 32'd2,        5'd13, 32'h7FFF_FFFC, OP_LAT);
        do_op("divu_100",   3'd5, 32'd100,       32'd7,        5'd14, 32'd14,        OP_LAT);
        do_op("remu_100",   3'd7, 32'd100,       32'd7,        5'd15, 32'd2,         OP_LAT);
        do_op("div_by0",    3'd4, 32'd5,         32'd0,        5'd16, 32'hFFFF_FFFF, SPEC_LAT);
        do_op("remu_by0",   3'd7, 32'd5,         32'd0,        5'd17, 32'd5,         SPEC_LAT);
        do_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, SPEC_LAT);
        do_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         SPEC_LAT);

        // Reset at edge N+10 of a DIV aborts it without any pulse
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr = 5'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy",   32'(busy), 32'd0);
        check("abort_done",   32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || wb_en) cnt++;
        end
        check("abort_no_pulse", 32'(cnt), 32'd0);
        $display("[TB] abort DIV at N+10 -> busy=%0b done=%0b result=%h", busy, done, result);
        do_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 5'd4, 32'd12, OP_LAT);

        // start held high while busy: only the first op is accepted
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'd6; rs2_data = 32'd7; rd_addr = 5'd9;
        @(posedge clk);
        #1;
        cnt = 0; lat = 0; got = '0;
        for (int i = 1; i <= 80; i++) begin
            if (i <= 34) begin
                rs1_data = 32'(100 + i);
                funct3   = 3'(i % 8);
                rd_addr  = 5'(i);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                cnt++;
                lat = i;
                got = result;
            end
        end
        check("held_start_count",   32'(cnt), 32'd1);
        check("held_start_latency", 32'(lat), 32'(OP_LAT));
        check("held_start_result",  got, 32'd42);
        check("held_start_wb_addr", 32'(wb_addr), 32'd9);
        $display("[TB] held start MUL 6x7 -> dones=%0d lat=%0d result=%h", cnt, lat, got);

        do_op("mul_rd0", 3'd0, 32'd2, 32'd2, 5'd0, 32'd4, OP_LAT);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
